// File: rtl/arrow_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : arrow_sequencer
// Brief    : Three-slot dance-arrow stream built from a shaped 16-bit Galois
//            LFSR. Define ARROW_SEQ_COUNT_EN to add the step_count output.
// Revision : 1.0 - initial release
// ============================================================================
module arrow_sequencer #(
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          MAX_REPEAT    = 2,
    parameter int          MAX_EMPTY_RUN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       pause,
    input  logic       step,
    output logic [2:0] slot0,
    output logic [2:0] slot1,
    output logic [2:0] slot2,
    output logic       step_valid,
    output logic       active
`ifdef ARROW_SEQ_COUNT_EN
    ,
    output logic [7:0] step_count
`endif
);

    localparam logic [15:0] c_SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] c_TAPS    = 16'hB400;
    localparam logic [7:0]  c_MAX_REP = 8'(MAX_REPEAT);
    localparam logic [7:0]  c_MAX_EMP = 8'(MAX_EMPTY_RUN);
    localparam logic [2:0]  c_EMPTY   = 3'd4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  slot0_q, slot0_d;
    logic [2:0]  slot1_q, slot1_d;
    logic [2:0]  slot2_q, slot2_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  rep_q, rep_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  empty_q, empty_d;
    logic        valid_q, valid_d;
    logic        active_q, active_d;
`ifdef ARROW_SEQ_COUNT_EN
    logic [7:0]  cnt_q, cnt_d;
`endif

    logic [2:0] cand;
    logic       is_arrow;
    logic [1:0] arrow;
    logic [2:0] code;
    logic       accept;

    assign cand   = lfsr_q[2:0];
    assign accept = (state_q == S_RUN) && run && !pause && step;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: run low always wins over pause
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_RUN;
            S_RUN: begin
                if (!run)      state_d = S_IDLE;
                else if (pause) state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (!run)       state_d = S_IDLE;
                else if (!pause) state_d = S_RUN;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Code shaping: raw candidate, anti-empty-run and anti-repeat rules
    // ------------------------------------------------------------------
    always_comb begin
        is_arrow = 1'b1;
        arrow    = lfsr_q[4:3];
        if (cand < 3'd4) begin
            arrow = cand[1:0];
        end else if ((cand == 3'd4) && (empty_q != c_MAX_EMP)) begin
            is_arrow = 1'b0;
        end
        if (is_arrow && (arrow == last_q) && (rep_q == c_MAX_REP)) begin
            arrow = arrow + 2'd1;
        end
        code = is_arrow ? {1'b0, arrow} : c_EMPTY;
    end

    // ------------------------------------------------------------------
    // Output / datapath next values; IDLE (including run fall) reloads all
    // ------------------------------------------------------------------
    always_comb begin
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        slot2_d  = slot2_q;
        lfsr_d   = lfsr_q;
        rep_d    = rep_q;
        last_d   = last_q;
        empty_d  = empty_q;
        valid_d  = 1'b0;
        active_d = (state_d != S_IDLE);
`ifdef ARROW_SEQ_COUNT_EN
        cnt_d    = cnt_q;
`endif
        if (state_d == S_IDLE) begin
            slot0_d = c_EMPTY;
            slot1_d = c_EMPTY;
            slot2_d = c_EMPTY;
            lfsr_d  = c_SEED;
            rep_d   = 8'd0;
            last_d  = 2'd0;
            empty_d = 8'd0;
`ifdef ARROW_SEQ_COUNT_EN
            cnt_d   = 8'd0;
`endif
        end else if (accept) begin
            slot2_d = slot1_q;
            slot1_d = slot0_q;
            slot0_d = code;
            valid_d = 1'b1;
            lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? c_TAPS : 16'h0000);
            if (is_arrow) begin
                empty_d = 8'd0;
                if (arrow == last_q) begin
                    if (rep_q != c_MAX_REP) rep_d = rep_q + 8'd1;
                end else begin
                    rep_d  = 8'd1;
                    last_d = arrow;
                end
            end else begin
                empty_d = empty_q + 8'd1;
            end
`ifdef ARROW_SEQ_COUNT_EN
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot0_q  <= c_EMPTY;
            slot1_q  <= c_EMPTY;
            slot2_q  <= c_EMPTY;
            lfsr_q   <= c_SEED;
            rep_q    <= 8'd0;
            last_q   <= 2'd0;
            empty_q  <= 8'd0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            slot2_q  <= slot2_d;
            lfsr_q   <= lfsr_d;
            rep_q    <= rep_d;
            last_q   <= last_d;
            empty_q  <= empty_d;
            valid_q  <= valid_d;
            active_q <= active_d;
        end
    end

`ifdef ARROW_SEQ_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_count = cnt_q;
`endif

    assign slot0      = slot0_q;
    assign slot1      = slot1_q;
    assign slot2      = slot2_q;
    assign step_valid = valid_q;
    assign active     = active_q;

endmodule
`default_nettype wire

// File: doc/arrow_sequencer.md
Name: arrow_sequencer

Overview:
- Generates the dance-arrow stream for the three on-screen arrow slots.
- Sits directly upstream of the arrow-value adjust / comparator / health stage.
- On each event tick it shifts the slots and inserts one new code.
- Codes come from a 16-bit Galois LFSR, shaped by anti-repeat and anti-empty-run rules; the stream is deterministic from game start.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR load value on reset and on return to IDLE; 0 is replaced by 16'h0001.
- MAX_REPEAT, 2, max consecutive identical non-empty arrows.
- MAX_EMPTY_RUN, 2, max consecutive empty codes.

Ports:
- clk  in  1  system clock; everything is synchronous to it.
- reset  in  1  asynchronous, active-low (0 = reset).
- run  in  1  game active level (start toggle).
- pause  in  1  freeze level.
- step  in  1  one-clk event pulse from the event timer, synchronous to clk.
- slot0  out  3  newest code: 0-3 arrow, 4 empty.
- slot1  out  3  middle slot code.
- slot2  out  3  oldest slot code.
- step_valid  out  1  one-clk pulse, coincident with updated slots.
- active  out  1  1 while in RUN or PAUSED.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; slot0/1/2=4; step_valid=0; active=0.
  - lfsr=seed; rep_cnt=0; last_arrow=0; empty_cnt=0.
- IDLE:
  - Slots held at 4.
  - run=0: lfsr held at seed.
  - run=1: go to RUN next clk, lfsr not advanced.
- RUN:
  - run=0: go to IDLE next clk (see run fall below).
  - pause=1: go to PAUSED.
  - Accepted step: step=1 & pause=0 & run=1.
- PAUSED:
  - Everything frozen; step ignored.
  - pause=0: back to RUN.
  - run=0: go to IDLE.
- Accepted step, code generation from the current lfsr value L:
  - cand = L[2:0].
  - cand 5..7 → arrow L[4:3].
  - cand 4 with empty_cnt==MAX_EMPTY_RUN → arrow L[4:3].
  - cand 4 otherwise → empty (4).
  - Arrow a with a==last_arrow and rep_cnt==MAX_REPEAT → a=(a+1) mod 4 (2-bit wrap).
- Accepted step, update (one clk latency; all take effect on the next edge):
  - slot2<=slot1; slot1<=slot0; slot0<=code; step_valid=1.
  - lfsr advances once: L>>1, XOR 16'hB400 if L[0]=1.
- Counters:
  - Arrow equal to last_arrow → rep_cnt+1 (saturates at MAX_REPEAT).
  - Arrow different from last_arrow → rep_cnt=1, last_arrow=arrow.
  - Arrow → empty_cnt=0.
  - Empty → empty_cnt+1; rep_cnt and last_arrow unchanged.
- Simultaneous events:
  - step together with pause=1 → dropped, no pulse.
  - step arriving on the IDLE→RUN cycle → dropped.
  - step and run fall on the same clk → step dropped.
- Run fall: slots→4, lfsr/counters→reset values on the next clk, from RUN or PAUSED.
- active: registered; 1 in RUN/PAUSED.
- Outputs: all registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: ARROW_SEQ_COUNT_EN.
- Defined:
  - Adds output step_count [7:0].
  - Counts accepted steps and saturates at 255.
  - Cleared by reset and on entry to IDLE.
- Undefined:
  - Port and counter absent.
  - All other behaviour identical.

Test Plan:
- Reset: reset=0 mid-RUN, slots nonzero → immediately slot0/1/2=4/4/4, step_valid=0, active=0, with no clk edge needed.
- Golden sequence: default seed; release reset with run=1; 1 idle clk; then 4 single steps spaced ≥2 clk apart.
  - (slot0,slot1,slot2) after each step: (1,4,4), (0,1,4), (0,0,1), (4,0,0).
  - step_valid pulses exactly 4 times.
- Pause: pause=1 with step pulses ×3 → slots unchanged, no step_valid. pause=0, then one step → (slot0,slot1,slot2)=(next golden code,4,0,0 shifted) and lfsr continues the golden sequence.
- Run fall: run=0 after 3 steps → next clk slots 4/4/4, active=0. run=1 again → golden sequence repeats from code 1.
- Constraint rules (force LFSR_SEED so raw cands give 4,4,4,4):
  - 3rd code is the arrow L[4:3], not empty.
  - Repeated arrow 2 three times (MAX_REPEAT=2) → 3rd becomes 3.
- Optional feature: with ARROW_SEQ_COUNT_EN, 300 steps → step_count=255; run fall → 0.
